kmkz_writeback_ahb: RTL and testbench
=====================================

// Module: kmkz_writeback_ahb
// PURPOSE
//  Parametrised writeback stage for the Kamikaze-uRV pipeline: selects the rd result (ALU/shifter/multiplier/load),
//  extracts and sign-extends load data, lane-replicates and registers store data onto AHB HWDATA.
//  Unlike the single-cycle predecessor it tracks the AHB data phase with an FSM, handles HRESP ERROR,
//  buffers a bus completion that lands during w_stall_i, and reports bus faults to the trap logic.
// PARAMETERS
//  TIMEOUT_CYC    256  data-phase wait cycles before bus-timeout fault (used only with KMKZ_WB_TIMEOUT_EN)
//  TIMEOUT_W      9    counter width; must satisfy 2**TIMEOUT_W > TIMEOUT_CYC
//  ERR_WRITE_ZERO 0    0: a faulted load suppresses the rd write; 1: the faulted load writes 32'h0 to rd
// PORTS
//  clk_i                  in   1   clock
//  rst_i                  in   1   asynchronous reset, active-low
//  w_stall_i              in   1   downstream stall; x_* inputs are held stable while high
//  w_stall_req_o          out  1   stall request to the pipeline (memory op not yet complete)
//  x_valid_i              in   1   execute-stage instruction valid
//  x_load_i / x_store_i   in   1   memory op type
//  x_fun_i                in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  x_dm_addr_i            in   32  data address; [1:0] selects the byte lane
//  x_rd_i                 in   5   destination register
//  x_rd_write_i           in   1   rd write enable (non-load ops)
//  x_rd_value_i / x_shifter_rd_value_i / x_multiply_rd_value_i  in  32  result candidates
//  x_rd_source_i          in   2   00 ALU, 01 shifter, 10 multiply, 11 ALU
//  x_store_data_i         in   32  raw rs2 value for stores
//  HWRITE_i / HTRANS1_i   in   1   address-phase write flag and HTRANS[1] as issued by the AHB master
//  HREADY / HRESP         in   1   AHB slave response (HRESP 1 = ERROR)
//  HRDATA                 in   32  AHB read data
//  HWDATA                 out  32  registered AHB write data
//  rf_rd_o                out  5   = x_rd_i
//  rf_rd_value_o          out  32  register-file write data
//  rf_rd_write_o          out  1   register-file write strobe
//  w_fault_o              out  1   one-cycle bus-fault pulse
//  w_fault_addr_o         out  32  address of the faulting access
//  w_fault_store_o        out  1   1 = faulting access was a store
// BEHAVIOUR
//  Reset: HWDATA=0, w_fault_o=0, w_fault_addr_o=0, w_fault_store_o=0, FSM=IDLE, hold_vld=0, counter=0.
//   rf_rd_write_o and w_stall_req_o are forced to 0 while rst_i is low.
//  mem_op = x_valid_i & (x_load_i | x_store_i). ok = HREADY & !HRESP. err = HREADY & HRESP.
//  HWDATA: loaded when HTRANS1_i & HWRITE_i & HREADY. B -> {4{d[7:0]}}, H -> {2{d[15:0]}}, W -> d.
//  Load extract from HRDATA by addr[1:0]. B/H sign bit comes from the selected lane of HRDATA.
//   H uses addr[1] only. Misalignment is checked upstream.
//  FSM:
//   IDLE: mem_op & ok -> complete this cycle, stay IDLE. mem_op & !HREADY -> WAIT (clear counter).
//         mem_op & err -> complete with fault.
//   WAIT: counter increments each cycle. ok/err -> complete, go to IDLE.
//   DRAIN (timeout only): entered when the counter reaches TIMEOUT_CYC; fault raised, op retired.
//         Stays until HREADY=1; a new mem_op is held stalled meanwhile.
//  Completion with w_stall_i=0: rf_rd_write_o=x_valid_i for loads (or 0 on fault, unless ERR_WRITE_ZERO).
//  Completion with w_stall_i=1: the load value or fault is captured into hold_vld/hold_data/hold_err.
//   On the first cycle with w_stall_i=0 the held result is written (hold source overrides HRDATA),
//   then hold_vld clears. While hold_vld=1, w_stall_req_o=0 and the bus is not observed.
//  Non-memory ops: rf_rd_write_o = x_rd_write_i & x_valid_i & !w_stall_i, zero latency.
//  w_stall_req_o = mem_op & !hold_vld & !(completion this cycle); also 1 in DRAIN while mem_op.
//  Fault: w_fault_o pulses 1 cycle, registered (cycle after completion). w_fault_addr_o and
//   w_fault_store_o are latched at the same edge and hold until the next fault.
//  Reset mid-transfer: FSM returns to IDLE, the hold register is cleared and the pending result is dropped.
// CONFIGURATION
//  KMKZ_WB_TIMEOUT_EN defined: the counter and DRAIN state are built; a WAIT lasting TIMEOUT_CYC cycles
//   raises a fault (store flag per op, address = x_dm_addr_i).
//  Undefined: no counter; WAIT persists until HREADY; DRAIN is unreachable and not synthesised.
// TESTING
//  LB addr[1:0]=11, HRDATA=32'h80_00_00_00, HREADY=1 -> rf_rd_value_o=32'hFFFFFF80, rf_rd_write_o=1 same cycle.
//  SH data 32'h0000_ABCD, address phase accepted -> next cycle HWDATA=32'hABCD_ABCD.
//  LW, HREADY low 3 cycles then ok -> w_stall_req_o=1 for 3 cycles, write on the 4th cycle, no fault.
//  LW at 32'h4000_0010, HRESP=1 HREADY=0 then HRESP=1 HREADY=1 -> no rd write;
//   next cycle w_fault_o=1, w_fault_addr_o=32'h4000_0010, w_fault_store_o=0.
//  LHU completes (HRDATA=32'h1234_5678, addr[1]=1) while w_stall_i=1 for 2 cycles ->
//   on w_stall_i fall, rf_rd_value_o=32'h0000_1234 and a single write strobe.
//  With KMKZ_WB_TIMEOUT_EN, TIMEOUT_CYC=4, SW with HREADY stuck low -> fault pulse after 4 WAIT cycles,
//   w_fault_store_o=1; stall holds in DRAIN until HREADY=1.

Source files
------------

// File: rtl/kmkz_writeback_ahb.sv
// kmkz_writeback_ahb -- Kamikaze-uRV writeback stage with AHB data-phase tracking.
// Selects the rd result, extracts and sign-extends load data, and drives the
// lane-replicated store data onto HWDATA. The data phase is followed by a small FSM
// that handles HRESP ERROR, parks a completion that lands while the pipeline is
// stalled, and reports bus faults to the trap logic.
// Optional feature: define KMKZ_WB_TIMEOUT_EN to build the data-phase timeout
// counter and the DRAIN state. Without it, WAIT lasts until HREADY.
module kmkz_writeback_ahb #(
  parameter int TIMEOUT_CYC    = 256,
  parameter int TIMEOUT_W      = 9,
  parameter bit ERR_WRITE_ZERO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_store_data_i,
  input  logic        HWRITE_i,
  input  logic        HTRANS1_i,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] HWDATA,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_fault_o,
  output logic [31:0] w_fault_addr_o,
  output logic        w_fault_store_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_hold_vld;
  logic        r_hold_wr;
  logic [31:0] r_hold_data;
  logic [31:0] r_hwdata;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic        r_fault_store;

  logic        w_mem_op;
  logic        w_timeout;
  logic        w_done;
  logic        w_err;
  logic        w_ld_wr_ok;
  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_ld_res;
  logic [31:0] w_alu_val;
  logic [31:0] w_store_rep;
  logic [31:0] w_value;
  logic        w_write;

  // A 2**TIMEOUT_W <= TIMEOUT_CYC setting is a configuration error; it shows up as
  // an (empty) g_bad_timeout_w scope in the elaborated hierarchy.
  if ((1 << TIMEOUT_W) <= TIMEOUT_CYC) begin : g_bad_timeout_w
  end

  assign w_mem_op = x_valid_i & (x_load_i | x_store_i);

`ifdef KMKZ_WB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] LP_CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  logic [TIMEOUT_W-1:0] r_cnt;

  // The last allowed WAIT cycle without HREADY retires the op as a fault.
  assign w_timeout = (r_state == S_WAIT) & w_mem_op & ~r_hold_vld & ~HREADY &
                     (r_cnt == LP_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // The op retires when the slave answers (outside DRAIN) or the timeout fires.
  // While a held result is pending the bus is ignored entirely.
  assign w_done     = w_mem_op & ~r_hold_vld &
                      (((r_state != S_DRAIN) & HREADY) | w_timeout);
  assign w_err      = w_done & ((HREADY & HRESP) | w_timeout);
  assign w_ld_wr_ok = ~w_err | ERR_WRITE_ZERO;

  // Split the read bus into byte lanes for the load extractor.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = HRDATA[8*gi +: 8];
  end

  assign w_byte = w_lane[x_dm_addr_i[1:0]];
  assign w_half = x_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];

  // Load extraction: sign bit taken from the selected lane; halfwords use addr[1] only.
  always_comb begin
    case (x_fun_i)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = HRDATA;
    endcase
  end

  // A faulted load carries zero so ERR_WRITE_ZERO builds write a clean value.
  assign w_ld_res = w_err ? 32'h0 : w_load_val;

  // Result selection for non-load instructions.
  always_comb begin
    case (x_rd_source_i)
      2'b01:   w_alu_val = x_shifter_rd_value_i;
      2'b10:   w_alu_val = x_multiply_rd_value_i;
      default: w_alu_val = x_rd_value_i;
    endcase
  end

  // Store data replicated across lanes so the slave picks the lane via HSIZE/HADDR.
  always_comb begin
    case (x_fun_i[1:0])
      2'b00:   w_store_rep = {4{x_store_data_i[7:0]}};
      2'b01:   w_store_rep = {2{x_store_data_i[15:0]}};
      default: w_store_rep = x_store_data_i;
    endcase
  end

  // Register-file write port: held result first, then loads, then plain ALU ops.
  always_comb begin
    w_value = w_alu_val;
    w_write = 1'b0;
    if (r_hold_vld) begin
      w_value = r_hold_data;
      w_write = r_hold_wr & ~w_stall_i;
    end else if (w_mem_op & x_load_i) begin
      w_value = w_ld_res;
      w_write = w_done & ~w_stall_i & w_ld_wr_ok;
    end else if (!w_mem_op) begin
      w_write = x_rd_write_i & x_valid_i & ~w_stall_i;
    end
  end

  assign rf_rd_o       = x_rd_i;
  assign rf_rd_value_o = w_value;
  assign rf_rd_write_o = w_write & rst_i;
  assign w_stall_req_o = rst_i & w_mem_op & ~r_hold_vld & ~w_done;

  assign HWDATA          = r_hwdata;
  assign w_fault_o       = r_fault;
  assign w_fault_addr_o  = r_fault_addr;
  assign w_fault_store_o = r_fault_store;

  // Data-phase FSM (and timeout counter when built).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
`ifdef KMKZ_WB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op & ~r_hold_vld & ~HREADY) begin
            r_state <= S_WAIT;
`ifdef KMKZ_WB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (~w_mem_op | HREADY) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_DRAIN;
          end else begin
`ifdef KMKZ_WB_TIMEOUT_EN
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        S_DRAIN: begin
          if (HREADY) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // HWDATA follows the accepted write address phase into the data phase.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hwdata <= 32'h0;
    end else if (HTRANS1_i & HWRITE_i & HREADY) begin
      r_hwdata <= w_store_rep;
    end
  end

  // Fault pulse one cycle after the faulting completion; address/type sticky.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fault       <= 1'b0;
      r_fault_addr  <= 32'h0;
      r_fault_store <= 1'b0;
    end else begin
      r_fault <= w_err;
      if (w_err) begin
        r_fault_addr  <= x_dm_addr_i;
        r_fault_store <= x_store_i;
      end
    end
  end

  // Park a completion that lands under stall; release on the first unstalled cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hold_vld  <= 1'b0;
      r_hold_wr   <= 1'b0;
      r_hold_data <= 32'h0;
    end else if (r_hold_vld) begin
      if (!w_stall_i) begin
        r_hold_vld <= 1'b0;
      end
    end else if (w_done & w_stall_i) begin
      r_hold_vld  <= 1'b1;
      r_hold_wr   <= x_load_i & w_ld_wr_ok;
      r_hold_data <= w_ld_res;
    end
  end

endmodule

// File: tb/tb_kmkz_writeback_ahb.sv
// Directed bench for kmkz_writeback_ahb: a vector table for single-cycle
// behaviour plus hand-written sequences for wait states, faults, stall hold,
// reset and (when KMKZ_WB_TIMEOUT_EN is defined) the data-phase timeout.
module tb_kmkz_writeback_ahb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_stall_i;
  logic        w_stall_req_o;
  logic        x_valid_i;
  logic        x_load_i;
  logic        x_store_i;
  logic [2:0]  x_fun_i;
  logic [31:0] x_dm_addr_i;
  logic [4:0]  x_rd_i;
  logic        x_rd_write_i;
  logic [31:0] x_rd_value_i;
  logic [31:0] x_shifter_rd_value_i;
  logic [31:0] x_multiply_rd_value_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_store_data_i;
  logic        HWRITE_i;
  logic        HTRANS1_i;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] HWDATA;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic        w_fault_o;
  logic [31:0] w_fault_addr_o;
  logic        w_fault_store_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  kmkz_writeback_ahb #(
    .TIMEOUT_CYC   (4),
    .TIMEOUT_W     (3),
    .ERR_WRITE_ZERO(1'b0)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .w_stall_i            (w_stall_i),
    .w_stall_req_o        (w_stall_req_o),
    .x_valid_i            (x_valid_i),
    .x_load_i             (x_load_i),
    .x_store_i            (x_store_i),
    .x_fun_i              (x_fun_i),
    .x_dm_addr_i          (x_dm_addr_i),
    .x_rd_i               (x_rd_i),
    .x_rd_write_i         (x_rd_write_i),
    .x_rd_value_i         (x_rd_value_i),
    .x_shifter_rd_value_i (x_shifter_rd_value_i),
    .x_multiply_rd_value_i(x_multiply_rd_value_i),
    .x_rd_source_i        (x_rd_source_i),
    .x_store_data_i       (x_store_data_i),
    .HWRITE_i             (HWRITE_i),
    .HTRANS1_i            (HTRANS1_i),
    .HREADY               (HREADY),
    .HRESP                (HRESP),
    .HRDATA               (HRDATA),
    .HWDATA               (HWDATA),
    .rf_rd_o              (rf_rd_o),
    .rf_rd_value_o        (rf_rd_value_o),
    .rf_rd_write_o        (rf_rd_write_o),
    .w_fault_o            (w_fault_o),
    .w_fault_addr_o       (w_fault_addr_o),
    .w_fault_store_o      (w_fault_store_o)
  );

  typedef struct {
    logic        v;
    logic        ld;
    logic        st;
    logic [2:0]  fun;
    logic [1:0]  a;
    logic        rdw;
    logic [1:0]  src;
    logic [31:0] hr;
    logic [31:0] sd;
    logic [31:0] ev;
    logic        ew;
    logic [31:0] ehw;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    x_valid_i      = 1'b0;
    x_load_i       = 1'b0;
    x_store_i      = 1'b0;
    x_fun_i        = 3'b010;
    x_dm_addr_i    = 32'h0;
    x_rd_write_i   = 1'b0;
    x_rd_source_i  = 2'b00;
    x_store_data_i = 32'h0;
    HWRITE_i       = 1'b0;
    HTRANS1_i      = 1'b0;
    HREADY         = 1'b1;
    HRESP          = 1'b0;
    HRDATA         = 32'h0;
    w_stall_i      = 1'b0;
  endtask

  task automatic load_op(input logic [2:0] fun, input logic [31:0] addr);
    idle_inputs();
    x_valid_i   = 1'b1;
    x_load_i    = 1'b1;
    x_fun_i     = fun;
    x_dm_addr_i = addr;
  endtask

  task automatic store_op(input logic [2:0] fun, input logic [31:0] addr);
    idle_inputs();
    x_valid_i   = 1'b1;
    x_store_i   = 1'b1;
    x_fun_i     = fun;
    x_dm_addr_i = addr;
  endtask

  logic        pend_hw;
  logic [31:0] pend_exp;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h1111_1111, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 2'd1, 32'h0, 32'h0, 32'h2222_2222, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h3333_3333, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h1111_1111, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 1'b0, 2'd0, 32'h8000_0000, 32'h0, 32'hFFFF_FF80, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b100, 2'd3, 1'b0, 2'd0, 32'h8000_0000, 32'h0, 32'h0000_0080, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 1'b0, 2'd0, 32'h0000_7F00, 32'h0, 32'h0000_007F, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b001, 2'd2, 1'b0, 2'd0, 32'h8001_1234, 32'h0, 32'hFFFF_8001, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b101, 2'd2, 1'b0, 2'd0, 32'h8001_1234, 32'h0, 32'h0000_8001, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b001, 2'd0, 1'b0, 2'd0, 32'h8001_1234, 32'h0, 32'h0000_1234, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_ABCD, 32'h1111_1111, 1'b0, 32'hABCD_ABCD};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_00A5, 32'h1111_1111, 1'b0, 32'hA5A5_A5A5};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 1'b0, 2'd0, 32'h0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h1234_5678};

    x_rd_i                = 5'd7;
    x_rd_value_i          = 32'h1111_1111;
    x_shifter_rd_value_i  = 32'h2222_2222;
    x_multiply_rd_value_i = 32'h3333_3333;
    idle_inputs();
    rst_i = 1'b0;

    // ---- reset state and output gating while in reset ----
    repeat (2) @(negedge clk_i);
    x_valid_i    = 1'b1;
    x_rd_write_i = 1'b1;
    #2;
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_fault", {31'h0, w_fault_o}, 32'h0);
    chk("rst_fault_addr", w_fault_addr_o, 32'h0);
    chk("rst_fault_store", {31'h0, w_fault_store_o}, 32'h0);
    chk("rst_rd_write_gated", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    load_op(3'b010, 32'h0);
    HREADY = 1'b0;
    #2;
    chk("rst_stall_gated", {31'h0, w_stall_req_o}, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    $display("reset sequence done");

    // ---- single-cycle vector table ----
    pend_hw  = 1'b0;
    pend_exp = 32'h0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (pend_hw) chk("hwdata", HWDATA, pend_exp);
      idle_inputs();
      x_valid_i      = vecs[i].v;
      x_load_i       = vecs[i].ld;
      x_store_i      = vecs[i].st;
      x_fun_i        = vecs[i].fun;
      x_dm_addr_i    = {30'h0400_0000, vecs[i].a};
      x_rd_write_i   = vecs[i].rdw;
      x_rd_source_i  = vecs[i].src;
      HRDATA         = vecs[i].hr;
      x_store_data_i = vecs[i].sd;
      HTRANS1_i      = vecs[i].st;
      HWRITE_i       = vecs[i].st;
      x_rd_i         = 5'(i + 3);
      #2;
      chk("vec_value", rf_rd_value_o, vecs[i].ev);
      chk("vec_write", {31'h0, rf_rd_write_o}, {31'h0, vecs[i].ew});
      chk("vec_stall", {31'h0, w_stall_req_o}, 32'h0);
      chk("vec_rd", {27'h0, rf_rd_o}, {27'h0, 5'(i + 3)});
      $display("vec %0d: value=%h write=%0b", i, rf_rd_value_o, rf_rd_write_o);
      pend_hw  = vecs[i].st;
      pend_exp = vecs[i].ehw;
    end
    @(negedge clk_i);
    if (pend_hw) chk("hwdata", HWDATA, pend_exp);
    idle_inputs();

    // ---- LW with three wait states ----
    @(negedge clk_i);
    load_op(3'b010, 32'h0000_0100);
    HREADY = 1'b0;
    #2;
    chk("wait_stall_c1", {31'h0, w_stall_req_o}, 32'h1);
    chk("wait_wr_c1", {31'h0, rf_rd_write_o}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      #2;
      chk("wait_stall_cn", {31'h0, w_stall_req_o}, 32'h1);
      chk("wait_wr_cn", {31'h0, rf_rd_write_o}, 32'h0);
    end
    @(negedge clk_i);
    HREADY = 1'b1;
    HRDATA = 32'hCAFE_F00D;
    #2;
    chk("wait_stall_done", {31'h0, w_stall_req_o}, 32'h0);
    chk("wait_wr_done", {31'h0, rf_rd_write_o}, 32'h1);
    chk("wait_value", rf_rd_value_o, 32'hCAFE_F00D);
    @(negedge clk_i);
    idle_inputs();
    #2;
    chk("wait_no_fault", {31'h0, w_fault_o}, 32'h0);
    $display("wait-state load done");

    // ---- LW with HRESP ERROR ----
    @(negedge clk_i);
    load_op(3'b010, 32'h4000_0010);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #2;
    chk("err_stall_c1", {31'h0, w_stall_req_o}, 32'h1);
    @(negedge clk_i);
    HREADY = 1'b1;
    #2;
    chk("err_stall_c2", {31'h0, w_stall_req_o}, 32'h0);
    chk("err_no_write", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    #2;
    chk("err_fault", {31'h0, w_fault_o}, 32'h1);
    chk("err_fault_addr", w_fault_addr_o, 32'h4000_0010);
    chk("err_fault_store", {31'h0, w_fault_store_o}, 32'h0);
    @(negedge clk_i);
    #2;
    chk("err_fault_pulse", {31'h0, w_fault_o}, 32'h0);
    chk("err_addr_sticky", w_fault_addr_o, 32'h4000_0010);
    $display("load bus error done");

    // ---- SW with HRESP ERROR ----
    @(negedge clk_i);
    store_op(3'b010, 32'h0000_0080);
    HRESP = 1'b1;
    #2;
    chk("serr_stall", {31'h0, w_stall_req_o}, 32'h0);
    chk("serr_no_write", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    #2;
    chk("serr_fault", {31'h0, w_fault_o}, 32'h1);
    chk("serr_fault_store", {31'h0, w_fault_store_o}, 32'h1);
    chk("serr_fault_addr", w_fault_addr_o, 32'h0000_0080);
    $display("store bus error done");

    // ---- LHU completing under w_stall_i for two cycles ----
    @(negedge clk_i);
    load_op(3'b101, 32'h0000_0002);
    HRDATA    = 32'h1234_5678;
    w_stall_i = 1'b1;
    #2;
    chk("hold_wr_c1", {31'h0, rf_rd_write_o}, 32'h0);
    chk("hold_stall_c1", {31'h0, w_stall_req_o}, 32'h0);
    @(negedge clk_i);
    HRDATA = 32'h0;
    HREADY = 1'b0;
    #2;
    chk("hold_wr_c2", {31'h0, rf_rd_write_o}, 32'h0);
    chk("hold_stall_c2", {31'h0, w_stall_req_o}, 32'h0);
    @(negedge clk_i);
    w_stall_i = 1'b0;
    #2;
    chk("hold_wr_release", {31'h0, rf_rd_write_o}, 32'h1);
    chk("hold_value", rf_rd_value_o, 32'h0000_1234);
    @(negedge clk_i);
    load_op(3'b010, 32'h0);
    HRDATA = 32'hAAAA_5555;
    #2;
    chk("hold_cleared_wr", {31'h0, rf_rd_write_o}, 32'h1);
    chk("hold_cleared_value", rf_rd_value_o, 32'hAAAA_5555);
    $display("stalled completion done");

    // ---- reset while a held result is pending ----
    @(negedge clk_i);
    load_op(3'b010, 32'h0);
    HRDATA    = 32'h5555_5555;
    w_stall_i = 1'b1;
    #2;
    chk("rhold_wr_c1", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    chk("rhold_wr_in_rst", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    rst_i     = 1'b1;
    w_stall_i = 1'b0;
    HRDATA    = 32'h7777_7777;
    #2;
    chk("rhold_value", rf_rd_value_o, 32'h7777_7777);
    chk("rhold_wr", {31'h0, rf_rd_write_o}, 32'h1);
    @(negedge clk_i);
    idle_inputs();
    $display("reset with pending hold done");

`ifdef KMKZ_WB_TIMEOUT_EN
    // ---- SW with HREADY stuck low: timeout after 4 WAIT cycles ----
    @(negedge clk_i);
    store_op(3'b010, 32'h0000_0020);
    HREADY = 1'b0;
    #2;
    chk("to_stall_idle", {31'h0, w_stall_req_o}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      #2;
      chk("to_stall_wait", {31'h0, w_stall_req_o}, 32'h1);
      chk("to_no_fault_yet", {31'h0, w_fault_o}, 32'h0);
    end
    @(negedge clk_i);
    #2;
    chk("to_retire", {31'h0, w_stall_req_o}, 32'h0);
    @(negedge clk_i);
    load_op(3'b010, 32'h0000_0030);
    HREADY = 1'b0;
    #2;
    chk("to_fault", {31'h0, w_fault_o}, 32'h1);
    chk("to_fault_store", {31'h0, w_fault_store_o}, 32'h1);
    chk("to_fault_addr", w_fault_addr_o, 32'h0000_0020);
    chk("to_drain_stall", {31'h0, w_stall_req_o}, 32'h1);
    @(negedge clk_i);
    HREADY = 1'b1;
    HRDATA = 32'h0BAD_F00D;
    #2;
    chk("to_drain_exit_stall", {31'h0, w_stall_req_o}, 32'h1);
    chk("to_drain_no_write", {31'h0, rf_rd_write_o}, 32'h0);
    @(negedge clk_i);
    #2;
    chk("to_next_stall", {31'h0, w_stall_req_o}, 32'h0);
    chk("to_next_wr", {31'h0, rf_rd_write_o}, 32'h1);
    chk("to_next_value", rf_rd_value_o, 32'h0BAD_F00D);
    @(negedge clk_i);
    idle_inputs();
    $display("timeout sequence done");
`else
    // ---- without the timeout, WAIT persists while HREADY is low ----
    @(negedge clk_i);
    store_op(3'b010, 32'h0000_0020);
    HREADY = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      #2;
      chk("nto_stall", {31'h0, w_stall_req_o}, 32'h1);
      chk("nto_no_fault", {31'h0, w_fault_o}, 32'h0);
    end
    @(negedge clk_i);
    HREADY = 1'b1;
    #2;
    chk("nto_done_stall", {31'h0, w_stall_req_o}, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    #2;
    chk("nto_done_no_fault", {31'h0, w_fault_o}, 32'h0);
    $display("long wait sequence done");
`endif

    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
